// File: rtl/cus19_imem_prefetch.sv
// cus19_imem_prefetch
// Instruction memory with an integrated prefetch queue for the Custom19 core.
// A synchronous-read program array is fetched sequentially from an internal
// fetch PC. Each word is tagged with its PC and handed to decode through a
// valid/ready FIFO. A branch redirect flushes queued and in-flight words.
//
// Optional feature macro: CUS19_IMEM_PARITY_EN
//   defined   : each mem word carries an even-parity bit, checked at the head
//   undefined : no parity storage, instr_parity_err tied low
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   load_en/addr/data  program-load write port (legal in any state)
//   fetch_en           permit new fetch issue
//   redirect/_pc       flush and restart fetching at redirect_pc
//   instr_valid/out/pc FIFO head (word and its PC)
//   instr_ready        decoder accepts the head
//   fifo_count         entries currently queued
//   instr_parity_err   parity mismatch on a valid head
module cus19_imem_prefetch #(
  parameter int                  PC_Width    = 11,
  parameter int                  Instr_Width = 19,
  parameter int                  FIFO_Depth  = 4,
  parameter logic [PC_Width-1:0] RESET_PC    = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_en,
  input  logic [PC_Width-1:0]             load_addr,
  input  logic [Instr_Width-1:0]          load_data,
  input  logic                            fetch_en,
  input  logic                            redirect,
  input  logic [PC_Width-1:0]             redirect_pc,
  output logic                            instr_valid,
  output logic [Instr_Width-1:0]          instr_out,
  output logic [PC_Width-1:0]             instr_pc,
  input  logic                            instr_ready,
  output logic [$clog2(FIFO_Depth):0]     fifo_count,
  output logic                            instr_parity_err
);

  localparam int PW = $clog2(FIFO_Depth);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_Depth);

`ifdef CUS19_IMEM_PARITY_EN
  localparam int MW = Instr_Width + 1;
`else
  localparam int MW = Instr_Width;
`endif

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  // Program image; intentionally not reset.
  logic [MW-1:0]       mem [0:2**PC_Width-1];

  state_t              state;
  logic [PC_Width-1:0] fetch_pc;
  logic [PC_Width-1:0] rd_pc;
  logic [MW-1:0]       rd_data;
  logic                rd_valid;

  logic [PC_Width-1:0] q_pc   [FIFO_Depth];
  logic [MW-1:0]       q_data [FIFO_Depth];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic [MW-1:0]       load_word;
  logic [CW:0]         occupancy;
  logic                issue;
  logic                push;
  logic                pop;

`ifdef CUS19_IMEM_PARITY_EN
  assign load_word = {^load_data, load_data};
`else
  assign load_word = load_data;
`endif

  // The in-flight word is reserved a slot; a same-cycle pop is not credited,
  // so a push can never find the FIFO full.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, rd_valid};
  assign issue     = (state == FETCH) && !redirect && (occupancy < DEPTH_V);
  assign push      = rd_valid && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;

  // Write port only; the read happens in the fetch block. Non-blocking
  // ordering gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < FIFO_Depth; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE:    if (fetch_en)  state <= FETCH;
        FETCH:   if (!fetch_en) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (redirect) begin
        rd_valid <= 1'b0;
        fetch_pc <= redirect_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        rd_valid <= issue;
        if (issue) begin
          rd_data  <= mem[fetch_pc];
          rd_pc    <= fetch_pc;
          fetch_pc <= fetch_pc + PC_Width'(1);
        end
        if (push) begin
          q_pc[wr_ptr]   <= rd_pc;
          q_data[wr_ptr] <= rd_data;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign fifo_count  = count;
  assign instr_valid = (count != '0);
  assign instr_out   = q_data[rd_ptr][Instr_Width-1:0];
  assign instr_pc    = q_pc[rd_ptr];

`ifdef CUS19_IMEM_PARITY_EN
  assign instr_parity_err = instr_valid &&
                            ((^q_data[rd_ptr][Instr_Width-1:0]) != q_data[rd_ptr][Instr_Width]);
`else
  assign instr_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_cus19_imem_prefetch.sv
// Testbench for cus19_imem_prefetch: directed stimulus with a scoreboard.
// Stimulus pushes the words the decoder should accept; independent monitors
// pop and compare on every valid/ready handshake. A second instance with
// RESET_PC=11'h7FE covers fetch PC wrap-around.
module tb_cus19_imem_prefetch;

  localparam int IW = 19;

`ifdef CUS19_IMEM_PARITY_EN
  localparam logic PERR2 = 1'b1;
`else
  localparam logic PERR2 = 1'b0;
`endif

  typedef struct {
    logic [10:0] pc;
    logic [18:0] data;
    logic        perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [10:0] load_addr = '0;
  logic [18:0] load_data = '0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [10:0] redirect_pc = '0;
  logic        instr_valid;
  logic [18:0] instr_out;
  logic [10:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        instr_parity_err;

  logic        w_load_en = 1'b0;
  logic [10:0] w_load_addr = '0;
  logic [18:0] w_load_data = '0;
  logic        w_fetch_en = 1'b0;
  logic        w_redirect = 1'b0;
  logic [10:0] w_redirect_pc = '0;
  logic        w_valid;
  logic [18:0] w_out;
  logic [10:0] w_pc;
  logic        w_ready = 1'b1;
  logic [2:0]  w_count;
  logic        w_perr;

  exp_t        exp_q[$];
  exp_t        wexp_q[$];
  logic [18:0] model [0:2047];
  int unsigned passed = 0;
  int unsigned total = 0;
  int unsigned hs = 0;

  always #5 clk = ~clk;

  cus19_imem_prefetch #(
    .PC_Width(11), .Instr_Width(19), .FIFO_Depth(4), .RESET_PC(11'h000)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .fifo_count(fifo_count),
    .instr_parity_err(instr_parity_err)
  );

  cus19_imem_prefetch #(
    .PC_Width(11), .Instr_Width(19), .FIFO_Depth(4), .RESET_PC(11'h7FE)
  ) u_wrap (
    .clk(clk), .rst(rst), .load_en(w_load_en), .load_addr(w_load_addr),
    .load_data(w_load_data), .fetch_en(w_fetch_en), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .instr_valid(w_valid), .instr_out(w_out),
    .instr_pc(w_pc), .instr_ready(w_ready), .fifo_count(w_count),
    .instr_parity_err(w_perr)
  );

  function automatic logic [18:0] init_word(input int unsigned a);
    case (a)
      0:       return 19'h00001;
      1:       return 19'h10002;
      2:       return 19'h20003;
      3:       return 19'h30004;
      default: return 19'(a * 37) ^ 19'h55000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic expect_pc(input logic [10:0] pc, input logic perr);
    exp_q.push_back('{pc, model[pc], perr});
  endtask

  // Handshakes are seen at the negedge before the edge that completes them.
  always @(negedge clk) begin
    exp_t e;
    if (rst && instr_valid && instr_ready) begin
      hs++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %0h, required no handshake", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", 32'(instr_pc), 32'(e.pc));
        chk("pop_data", 32'(instr_out), 32'(e.data));
        chk("pop_perr", 32'(instr_parity_err), 32'(e.perr));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && w_valid && w_ready && wexp_q.size() != 0) begin
      e = wexp_q.pop_front();
      chk("wrap_pc", 32'(w_pc), 32'(e.pc));
      chk("wrap_data", 32'(w_out), 32'(e.data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_n(input int unsigned n, output int unsigned cycles);
    int unsigned target;
    target = hs + n;
    cycles = 0;
    instr_ready = 1'b1;
    while (hs < target && cycles < 50) begin
      step();
      cycles++;
    end
    instr_ready = 1'b0;
    if (hs < target) begin
      total++;
      $display("FAIL accept_timeout: got %0d handshakes, required %0d", n - (target - hs), n);
    end
  endtask

  task automatic do_redirect(input logic [10:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    int unsigned lat;
    int unsigned cyc;

    for (int unsigned i = 0; i < 2048; i++) begin
      model[i] = init_word(i);
`ifdef CUS19_IMEM_PARITY_EN
      dut.mem[i]    = {^model[i], model[i]};
      u_wrap.mem[i] = {^model[i], model[i]};
`else
      dut.mem[i]    = model[i];
      u_wrap.mem[i] = model[i];
`endif
    end

    repeat (3) step();
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_out", 32'(instr_out), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_perr", 32'(instr_parity_err), 0);
    chk("rst_fetch_pc", 32'(dut.fetch_pc), 0);
    chk("rst_rd_valid", 32'(dut.rd_valid), 0);
    chk("rst_wrap_fetch_pc", 32'(u_wrap.fetch_pc), 32'h7FE);

    // Startup latency and backpressure from an empty queue.
    rst        = 1'b1;
    fetch_en   = 1'b1;
    w_fetch_en = 1'b1;
    wexp_q.push_back('{11'h7FE, model[11'h7FE], 1'b0});
    wexp_q.push_back('{11'h7FF, model[11'h7FF], 1'b0});
    wexp_q.push_back('{11'h000, model[0], 1'b0});
    wexp_q.push_back('{11'h001, model[1], 1'b0});
    lat = 0;
    for (int unsigned k = 1; k <= 10; k++) begin
      step();
      if (instr_valid) begin
        lat = k;
        break;
      end
    end
    chk("startup_latency", lat, 3);
    chk("first_pc", 32'(instr_pc), 0);

    repeat (8) step();
    chk("bp_count", 32'(fifo_count), 4);
    chk("bp_fetch_pc", 32'(dut.fetch_pc), 4);
    chk("bp_rd_valid", 32'(dut.rd_valid), 0);

    for (int unsigned p = 0; p < 5; p++) expect_pc(11'(p), 1'b0);
    accept_n(5, cyc);
    chk("drain_back_to_back", cyc, 5);

    // Redirect with PCs 5.. queued.
    repeat (8) step();
    chk("pre_redir_count", 32'(fifo_count), 4);
    chk("pre_redir_head", 32'(instr_pc), 5);
    do_redirect(11'h200);
    chk("redir_count", 32'(fifo_count), 0);
    chk("redir_valid", 32'(instr_valid), 0);
    chk("redir_rd_valid", 32'(dut.rd_valid), 0);
    chk("redir_fetch_pc", 32'(dut.fetch_pc), 32'h200);
    expect_pc(11'h200, 1'b0);
    expect_pc(11'h201, 1'b0);
    expect_pc(11'h202, 1'b0);
    step();
    chk("redir_valid_r1", 32'(instr_valid), 0);
    step();
    chk("redir_valid_r2", 32'(instr_valid), 1);
    chk("redir_pc_r2", 32'(instr_pc), 32'h200);
    accept_n(3, cyc);
    chk("redir_back_to_back", cyc, 3);

    // Load to mem[3] in the same cycle mem[3] is issued: read-first.
    repeat (6) step();
    do_redirect(11'h003);
    load_en   = 1'b1;
    load_addr = 11'h003;
    load_data = 19'h7FFFF;
    step();
    load_en = 1'b0;
    expect_pc(11'h003, 1'b0);
    expect_pc(11'h004, 1'b0);
    model[3] = 19'h7FFFF;
    step();
    accept_n(2, cyc);
    repeat (6) step();
    do_redirect(11'h003);
    expect_pc(11'h003, 1'b0);
    repeat (2) step();
    accept_n(1, cyc);

    // Parity: corrupt the stored parity bit of mem[2] when the feature exists.
    repeat (6) step();
`ifdef CUS19_IMEM_PARITY_EN
    dut.mem[2][IW] = ~dut.mem[2][IW];
`endif
    do_redirect(11'h001);
    expect_pc(11'h001, 1'b0);
    expect_pc(11'h002, PERR2);
    expect_pc(11'h003, 1'b0);
    repeat (2) step();
    chk("perr_head_pc1", 32'(instr_parity_err), 0);
    accept_n(3, cyc);

    repeat (4) step();
    chk("sb_empty", exp_q.size(), 0);
    chk("wrap_done", wexp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
